// File: rtl/toggle_pkg.sv
// Shared definitions for the two-phase toggle event channel (sender and receiver).
package toggle_pkg;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int CNT_W_DEF       = 4;

    // Action taken on the pending-event counter in a given cycle.
    typedef enum logic [1:0] {
        CNT_HOLD,
        CNT_INC,
        CNT_DEC,
        CNT_SAT
    } cnt_op_e;

    // Largest count a cnt_w-bit pending counter can hold.
    function automatic int cnt_max(input int cnt_w);
        return (1 << cnt_w) - 1;
    endfunction

endpackage

// File: rtl/toggle_event_rx_if.sv
// Event channel bundle between the toggle receiver (slave) and its surroundings:
// the incoming toggle line, the consumer handshake and the status/ack lines.
interface toggle_event_rx_if
    import toggle_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);

    logic             req_tgl;
    logic             evt_valid;
    logic             evt_ready;
    logic             ack_tgl;
    logic [CNT_W-1:0] pending;
    logic             overflow;
    logic             clr_ovf;

    modport slave (
        input  req_tgl,
        input  evt_ready,
        input  clr_ovf,
        output evt_valid,
        output ack_tgl,
        output pending,
        output overflow
    );

    modport master (
        output req_tgl,
        output evt_ready,
        output clr_ovf,
        input  evt_valid,
        input  ack_tgl,
        input  pending,
        input  overflow
    );

endinterface

// File: rtl/toggle_sync.sv
// Reset-to-zero flop chain that brings an asynchronous level into the clk domain.
// Also used on the sender side to bring ack_tgl back.
module toggle_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the raw input through the chain; the oldest stage is the safe output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/toggle_event_rx.sv
// Receiving end of the two-phase toggle event channel. Every transition of
// req_tgl becomes one queued event in a saturating pending counter; events are
// handed out over valid/ready and each accepted event flips ack_tgl.
module toggle_event_rx
    import toggle_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input logic              clk,
    input logic              rst_n,
    toggle_event_rx_if.slave bus
);

    localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(cnt_max(CNT_W));

    logic             s_out;
    logic             prev;
    logic             tgl_edge;
    logic             pop;
    logic [CNT_W-1:0] pend_q;
    logic             ack_q;
    logic             ovf_q;
    cnt_op_e          cnt_op;

    toggle_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.req_tgl),
        .q     (s_out)
    );

    assign tgl_edge = s_out ^ prev;
    assign pop      = (pend_q != '0) && bus.evt_ready;

    // Remember the last synchronised level so either transition direction is an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= 1'b0;
        end else begin
            prev <= s_out;
        end
    end

    // Pick the counter action; an edge and a pop together cancel, and an edge at full count is dropped.
    always_comb begin
        cnt_op = CNT_HOLD;
        if (tgl_edge && !pop) begin
            cnt_op = (pend_q == PEND_MAX) ? CNT_SAT : CNT_INC;
        end else if (pop && !tgl_edge) begin
            cnt_op = CNT_DEC;
        end
    end

    // Pending-event counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            case (cnt_op)
                CNT_INC: pend_q <= pend_q + 1'b1;
                CNT_DEC: pend_q <= pend_q - 1'b1;
                default: pend_q <= pend_q;
            endcase
        end
    end

    // Flip the acknowledge line once per consumed event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q <= 1'b0;
        end else if (pop) begin
            ack_q <= ~ack_q;
        end
    end

    // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (cnt_op == CNT_SAT) begin
            ovf_q <= 1'b1;
        end else if (bus.clr_ovf) begin
            ovf_q <= 1'b0;
        end
    end

    assign bus.evt_valid = (pend_q != '0);
    assign bus.pending   = pend_q;
    assign bus.ack_tgl   = ack_q;
    assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_toggle_event_rx.sv
// Directed bench for toggle_event_rx: a sample-history model predicts every
// output each cycle, and literal checks pin the key scenarios.
module tb_toggle_event_rx;
    import toggle_pkg::*;

    localparam int S    = SYNC_STAGES_DEF;
    localparam int W    = CNT_W_DEF;
    localparam int MAXP = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic reqVal;

    int vecCount  = 0;
    int missCount = 0;

    toggle_event_rx_if #(.CNT_W(W)) bus();

    toggle_event_rx #(
        .SYNC_STAGES (S),
        .CNT_W       (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Model state: req_tgl as sampled at recent rising edges, newest first.
    int histM [S+2];
    int pendM;
    bit ackM;
    bit ovfM;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic ready, input logic clr, input int cycles);
        bus.req_tgl   = req;
        bus.evt_ready = ready;
        bus.clr_ovf   = clr;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic applyReset(input logic reqLevel);
        rst_n         = 1'b0;
        bus.req_tgl   = reqLevel;
        bus.evt_ready = 1'b0;
        bus.clr_ovf   = 1'b0;
        #2;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Model: an event lands S edges after the sampled line changed; then apply the queue rules.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            foreach (histM[i]) histM[i] = 0;
            pendM = 0;
            ackM  = 1'b0;
            ovfM  = 1'b0;
        end else begin
            bit evt;
            bit popM;
            bit drop;
            for (int i = S + 1; i > 0; i--) histM[i] = histM[i-1];
            histM[0] = int'(bus.req_tgl);
            evt  = (histM[S] != histM[S+1]);
            popM = (pendM > 0) && bus.evt_ready;
            drop = evt && !popM && (pendM == MAXP);
            if (evt && !popM && !drop) pendM++;
            else if (popM && !evt) pendM--;
            if (popM) ackM = !ackM;
            if (drop) ovfM = 1'b1;
            else if (bus.clr_ovf) ovfM = 1'b0;
        end
    end

    // Every falling edge out of reset, the DUT must agree with the model.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checkOutput("model_pending", bus.pending, pendM);
            checkOutput("model_valid", bus.evt_valid, (pendM != 0) ? 1 : 0);
            checkOutput("model_ack", bus.ack_tgl, ackM);
            checkOutput("model_overflow", bus.overflow, ovfM);
        end
    end

    // Safety net so the run always ends.
    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.req_tgl   = 1'b0;
        bus.evt_ready = 1'b0;
        bus.clr_ovf   = 1'b0;
        reqVal        = 1'b0;
        #1;
        checkOutput("rst_pending", bus.pending, 0);
        checkOutput("rst_valid", bus.evt_valid, 0);
        checkOutput("rst_ack", bus.ack_tgl, 0);
        checkOutput("rst_overflow", bus.overflow, 0);
        #1 rst_n = 1'b1;

        // Three toggles so three events are queued by t=45.
        #1 bus.req_tgl = 1'b1;
        @(negedge clk) bus.req_tgl = 1'b0;
        @(negedge clk) bus.req_tgl = 1'b1;
        #26;
        checkOutput("pre_reset_pending", bus.pending, 3);

        // Mid-stream reset pulse at t=48 discards the queue at once.
        #2;
        rst_n       = 1'b0;
        bus.req_tgl = 1'b0;
        #1;
        checkOutput("midrst_pending", bus.pending, 0);
        checkOutput("midrst_valid", bus.evt_valid, 0);
        checkOutput("midrst_ack", bus.ack_tgl, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single toggle: visible exactly three edges later, then one pop.
        applyStimulus(1'b1, 1'b0, 1'b0, 2);
        checkOutput("latency_two_edges", bus.pending, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1);
        checkOutput("latency_pending", bus.pending, 1);
        checkOutput("latency_valid", bus.evt_valid, 1);
        checkOutput("latency_ack", bus.ack_tgl, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1);
        checkOutput("pop_pending", bus.pending, 0);
        checkOutput("pop_ack", bus.ack_tgl, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1);

        // Ready while empty must not pop.
        applyReset(1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 2);
        checkOutput("empty_ack", bus.ack_tgl, 0);
        checkOutput("empty_pending", bus.pending, 0);

        // Burst of five toggles, then drain.
        applyReset(1'b0);
        reqVal = 1'b0;
        for (int i = 0; i < 5; i++) begin
            reqVal = ~reqVal;
            applyStimulus(reqVal, 1'b0, 1'b0, 2);
        end
        applyStimulus(reqVal, 1'b0, 1'b0, 1);
        checkOutput("burst_pending", bus.pending, 5);
        applyStimulus(reqVal, 1'b1, 1'b0, 5);
        checkOutput("drain_pending", bus.pending, 0);
        checkOutput("drain_ack", bus.ack_tgl, 1);
        applyStimulus(reqVal, 1'b0, 1'b0, 1);

        // Edge and pop every cycle with two events queued.
        applyReset(1'b0);
        reqVal = 1'b0;
        for (int i = 0; i < 2; i++) begin
            reqVal = ~reqVal;
            applyStimulus(reqVal, 1'b0, 1'b0, 2);
        end
        applyStimulus(reqVal, 1'b0, 1'b0, 1);
        checkOutput("simul_start_pending", bus.pending, 2);
        for (int i = 0; i < 5; i++) begin
            reqVal = ~reqVal;
            applyStimulus(reqVal, (i >= 2) ? 1'b1 : 1'b0, 1'b0, 1);
        end
        applyStimulus(reqVal, 1'b1, 1'b0, 2);
        checkOutput("simul_pending", bus.pending, 2);
        checkOutput("simul_overflow", bus.overflow, 0);
        checkOutput("simul_ack", bus.ack_tgl, 1);
        applyStimulus(reqVal, 1'b0, 1'b0, 1);

        // Saturation, clear, and drop colliding with clear.
        applyReset(1'b0);
        reqVal = 1'b0;
        for (int i = 0; i < 16; i++) begin
            reqVal = ~reqVal;
            applyStimulus(reqVal, 1'b0, 1'b0, 1);
        end
        applyStimulus(reqVal, 1'b0, 1'b0, 1);
        checkOutput("full_pending", bus.pending, 15);
        checkOutput("full_no_ovf", bus.overflow, 0);
        applyStimulus(reqVal, 1'b0, 1'b0, 1);
        checkOutput("sat_pending", bus.pending, 15);
        checkOutput("sat_overflow", bus.overflow, 1);
        applyStimulus(reqVal, 1'b0, 1'b1, 1);
        checkOutput("clr_overflow", bus.overflow, 0);
        checkOutput("clr_pending", bus.pending, 15);
        reqVal = ~reqVal;
        applyStimulus(reqVal, 1'b0, 1'b0, 2);
        applyStimulus(reqVal, 1'b0, 1'b1, 1);
        checkOutput("drop_clr_overflow", bus.overflow, 1);
        checkOutput("drop_clr_pending", bus.pending, 15);
        applyStimulus(reqVal, 1'b0, 1'b0, 1);

        // Line already high at reset release counts once.
        applyReset(1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1);
        checkOutput("high_at_rst_early", bus.pending, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1);
        checkOutput("high_at_rst_pending", bus.pending, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 3);
        checkOutput("high_at_rst_once", bus.pending, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
